// File: rtl/vga_timing_gen_pkg.sv
// Shared video definitions: raster timing struct and standard 640x480@60 mode.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the timing source is free-running.
package vga_timing_gen_pkg;

  // Timing bundle consumed by the video controller; pulses are qualified by valid.
  typedef struct packed {
    logic valid;
    logic blank_n;
    logic hsync_n;
    logic vsync_n;
    logic end_of_visible_line;
    logic end_of_line;
    logic next_line_visible;
    logic end_of_frame;
  } vga_timing_t;

  // Standard 640x480@60 mode, dot rate = system clock / 2.
  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Idle bundle: no strobe, blanked, syncs deasserted (active-low, so high).
  function automatic vga_timing_t timing_idle();
    vga_timing_t t;
    t         = '0;
    t.hsync_n = 1'b1;
    t.vsync_n = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source with clock-enable dot divider, coordinates, frame count and vblank irq.
// Latency: every output is registered one clock after the counter state it describes.
// Backpressure: none; en_i low holds the raster at the origin (frame count kept).
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output vga_timing_t timing_o,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic [15:0] frame_o,
  output logic        vblank_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Region boundaries at counter width; back porches >= 1 keep every bound below the total.
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_VIS_END  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_VIS_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0]   HS_BEGIN   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_VIS_END  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_VIS_LAST = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0]   VS_BEGIN   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_ACTIVE < 1 || H_FP < 0 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h_mode
    $error("vga_timing_gen: horizontal mode needs ACTIVE, SYNC, BP >= 1 and FP >= 0");
  end
  if (V_ACTIVE < 1 || V_FP < 0 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v_mode
    $error("vga_timing_gen: vertical mode needs ACTIVE, SYNC, BP >= 1 and FP >= 0");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_coord_width
    $error("vga_timing_gen: raster does not fit the 10-bit coordinate outputs");
  end

  logic [DIV_W-1:0] div;
  logic [H_W-1:0]   h;
  logic [V_W-1:0]   v;
  logic [15:0]      frame;
  logic             strobe;
  logic             h_last;
  logic             v_last;
  vga_timing_t      timing_d;
  logic             irq_d;

  // Dot strobe and end-of-count flags for the current counter state.
  always_comb begin
    strobe = en_i && (div == DIV_LAST);
    h_last = (h == H_LAST);
    v_last = (v == V_LAST);
  end

  // Divider and raster counters; disable parks at the origin but keeps the frame count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div   <= '0;
      h     <= '0;
      v     <= '0;
      frame <= '0;
    end else if (!en_i) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (strobe) begin
      div <= '0;
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v     <= '0;
          frame <= frame + 16'd1;
        end else begin
          v <= v + V_W'(1);
        end
      end else begin
        h <= h + H_W'(1);
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Decode the current dot into levels and strobe-qualified event pulses.
  always_comb begin
    timing_d = timing_idle();
    irq_d    = 1'b0;
    if (en_i) begin
      timing_d.valid               = strobe;
      timing_d.blank_n             = (h < H_VIS_END) && (v < V_VIS_END);
      timing_d.hsync_n             = !((h >= HS_BEGIN) && (h < HS_END));
      timing_d.vsync_n             = !((v >= VS_BEGIN) && (v < VS_END));
      timing_d.end_of_visible_line = strobe && (h == H_VIS_LAST) && (v < V_VIS_END);
      timing_d.end_of_line         = strobe && h_last;
      // Line after the last one of the frame is line 0, which is always visible.
      timing_d.next_line_visible   = strobe && h_last && (v_last || (v < V_VIS_LAST));
      timing_d.end_of_frame        = strobe && h_last && v_last;
      irq_d                        = strobe && (h == '0) && (v == V_VIS_END);
    end
  end

  // Output register stage; levels are re-evaluated every clock so they hold between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timing_o   <= timing_idle();
      x_o        <= '0;
      y_o        <= '0;
      frame_o    <= '0;
      vblank_irq <= 1'b0;
    end else begin
      timing_o   <= timing_d;
      x_o        <= en_i ? 10'(h) : 10'd0;
      y_o        <= en_i ? 10'(v) : 10'd0;
      frame_o    <= frame;
      vblank_irq <= irq_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small CLK_DIV=2 mode, small CLK_DIV=1 mode, default 640x480 mode.
// Expected outputs come from a closed-form model indexed by enabled-clock count.
// Inputs are driven and outputs compared on the falling clock edge.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  localparam int A_D = 2, A_HA = 8,  A_HF = 1, A_HS = 2, A_HB = 1, A_VA = 4, A_VF = 1, A_VS = 1, A_VB = 1;
  localparam int B_D = 1, B_HA = 16, B_HF = 2, B_HS = 3, B_HB = 2, B_VA = 6, B_VF = 1, B_VS = 2, B_VB = 1;
  localparam int A_LINE_CLK  = (A_HA + A_HF + A_HS + A_HB) * A_D;
  localparam int A_FRAME_CLK = A_LINE_CLK * (A_VA + A_VF + A_VS + A_VB);
  localparam int B_FRAME_CLK = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB) * B_D;

  typedef struct packed {
    vga_timing_t tim;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fr;
    logic        irq;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  vga_timing_t tim_a, tim_b, tim_c;
  logic [9:0]  x_a, x_b, x_c, y_a, y_b, y_c;
  logic [15:0] fr_a, fr_b, fr_c;
  logic        irq_a, irq_b, irq_c;
  obs_t        obs [3];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(A_D), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .timing_o(tim_a),
    .x_o(x_a), .y_o(y_a), .frame_o(fr_a), .vblank_irq(irq_a)
  );

  vga_timing_gen #(
    .CLK_DIV(B_D), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .timing_o(tim_b),
    .x_o(x_b), .y_o(y_b), .frame_o(fr_b), .vblank_irq(irq_b)
  );

  vga_timing_gen dut_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .timing_o(tim_c),
    .x_o(x_c), .y_o(y_c), .frame_o(fr_c), .vblank_irq(irq_c)
  );

  assign obs[0] = {tim_a, x_a, y_a, fr_a, irq_a};
  assign obs[1] = {tim_b, x_b, y_b, fr_b, irq_b};
  assign obs[2] = {tim_c, x_c, y_c, fr_c, irq_c};

  // Mode table per instance: A, B, default.
  int cd [3] = '{A_D,  B_D,  VGA_CLK_DIV};
  int ha [3] = '{A_HA, B_HA, VGA_H_ACTIVE};
  int hf [3] = '{A_HF, B_HF, VGA_H_FP};
  int hs [3] = '{A_HS, B_HS, VGA_H_SYNC};
  int hb [3] = '{A_HB, B_HB, VGA_H_BP};
  int va [3] = '{A_VA, B_VA, VGA_V_ACTIVE};
  int vf [3] = '{A_VF, B_VF, VGA_V_FP};
  int vs [3] = '{A_VS, B_VS, VGA_V_SYNC};
  int vb [3] = '{A_VB, B_VB, VGA_V_BP};

  // Model state: clocks since the raster last restarted, and frame count at that restart.
  int   tt [3];
  int   fb [3];
  obs_t exp_q [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit ph1   = 1'b0;
  int last_vld_a = -1, last_eol_a = -1, last_eof_a = -1, last_irq_b = -1;
  int hs_min_c = 9999, hs_max_c = -1, vs_min_b = 9999, vs_max_b = -1;
  int eovl_c = 0, vld_b = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o     = '0;
    o.tim = timing_idle();
    return o;
  endfunction

  task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".tim"}, 32'(a.tim), 32'(e.tim));
    chk({tag, ".x"},   32'(a.x),   32'(e.x));
    chk({tag, ".y"},   32'(a.y),   32'(e.y));
    chk({tag, ".fr"},  32'(a.fr),  32'(e.fr));
    chk({tag, ".irq"}, 32'(a.irq), 32'(e.irq));
  endtask

  // Expected outputs after the coming clock edge for instance k.
  task automatic model_step(input int k, input logic en_now, output obs_t e);
    int   ht, vt, n, h, v, fr;
    logic stb;
    ht = ha[k] + hf[k] + hs[k] + hb[k];
    vt = va[k] + vf[k] + vs[k] + vb[k];
    n  = tt[k] / cd[k];
    h  = n % ht;
    v  = (n / ht) % vt;
    fr = (fb[k] + n / (ht * vt)) % 65536;
    e    = idle_obs();
    e.fr = 16'(fr);
    if (!en_now) begin
      fb[k] = fr;
      tt[k] = 0;
    end else begin
      stb = ((tt[k] % cd[k]) == cd[k] - 1);
      e.tim.valid               = stb;
      e.tim.blank_n             = (h < ha[k]) && (v < va[k]);
      e.tim.hsync_n             = !((h >= ha[k] + hf[k]) && (h < ha[k] + hf[k] + hs[k]));
      e.tim.vsync_n             = !((v >= va[k] + vf[k]) && (v < va[k] + vf[k] + vs[k]));
      e.tim.end_of_visible_line = stb && (h == ha[k] - 1) && (v < va[k]);
      e.tim.end_of_line         = stb && (h == ht - 1);
      e.tim.next_line_visible   = e.tim.end_of_line && ((v == vt - 1) ? 1'b1 : (v + 1 < va[k]));
      e.tim.end_of_frame        = e.tim.end_of_line && (v == vt - 1);
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.irq = stb && (h == 0) && (v == va[k]);
      tt[k]++;
    end
  endtask

  task automatic drive(input logic en_now);
    obs_t e;
    en = en_now;
    for (int k = 0; k < 3; k++) begin
      model_step(k, en_now, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_all();
    obs_t e;
    if (exp_q.size() < 3) begin
      chk("sb.depth", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      chk_obs($sformatf("d%0d.c%0d", k, cyc), obs[k], e);
    end
  endtask

  // Cadence and window statistics while running continuously enabled.
  task automatic stats();
    cyc++;
    if (!ph1) return;
    if (obs[0].tim.valid) begin
      if (last_vld_a >= 0) chk("a.valid_gap", 32'(cyc - last_vld_a), 32'(A_D));
      last_vld_a = cyc;
    end
    if (obs[0].tim.end_of_line) begin
      if (last_eol_a >= 0) chk("a.eol_gap", 32'(cyc - last_eol_a), 32'(A_LINE_CLK));
      last_eol_a = cyc;
    end
    if (obs[0].tim.end_of_frame) begin
      if (last_eof_a >= 0) chk("a.eof_gap", 32'(cyc - last_eof_a), 32'(A_FRAME_CLK));
      last_eof_a = cyc;
    end
    if (obs[1].irq) begin
      if (last_irq_b >= 0) chk("b.irq_gap", 32'(cyc - last_irq_b), 32'(B_FRAME_CLK));
      last_irq_b = cyc;
    end
    if (obs[1].tim.valid) vld_b++;
    if (obs[1].tim.valid && !obs[1].tim.vsync_n) begin
      if (int'(obs[1].y) < vs_min_b) vs_min_b = int'(obs[1].y);
      if (int'(obs[1].y) > vs_max_b) vs_max_b = int'(obs[1].y);
    end
    if (obs[2].tim.valid && !obs[2].tim.hsync_n) begin
      if (int'(obs[2].x) < hs_min_c) hs_min_c = int'(obs[2].x);
      if (int'(obs[2].x) > hs_max_c) hs_max_c = int'(obs[2].x);
    end
    if (obs[2].tim.end_of_visible_line) eovl_c++;
  endtask

  task automatic step(input logic en_now);
    @(negedge clk);
    compare_all();
    stats();
    drive(en_now);
  endtask

  // Steps until instance A strobes; reports the number of clocks taken.
  task automatic wait_strobe_a(input int budget, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b1);
      waited++;
      if (obs[0].tim.valid) seen = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          seen;
    int          waited;
    logic [15:0] fr_hold;
    rst_n = 1'b0;
    en    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tt[k] = 0;
      fb[k] = 0;
    end

    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_obs($sformatf("d%0d.reset", k), obs[k], idle_obs());
    rst_n = 1'b1;
    drive(1'b1);

    // Continuous run: several small frames, a few default-mode lines.
    ph1 = 1'b1;
    for (int i = 1; i <= 4000; i++) begin
      step(1'b1);
      if (i == 100) chk("a.frame0", 32'(obs[0].fr), 32'd0);
      if (i == 170) chk("a.frame1", 32'(obs[0].fr), 32'd1);
      if (i == 340) chk("a.frame2", 32'(obs[0].fr), 32'd2);
    end
    ph1 = 1'b0;
    chk("c.hsync_first", 32'(hs_min_c), 32'd656);
    chk("c.hsync_last",  32'(hs_max_c), 32'd751);
    chk("c.eovl_count",  32'(eovl_c),   32'd2);
    chk("b.vsync_first", 32'(vs_min_b), 32'(B_VA + B_VF));
    chk("b.vsync_last",  32'(vs_max_b), 32'(B_VA + B_VF + B_VS - 1));
    chk("b.valid_count", 32'(vld_b),    32'd4000);

    // Disable mid-line for five clocks, then restart from the origin.
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1'b1);
      if (obs[0].tim.valid && obs[0].x == 10'd5 && obs[0].y == 10'd2) seen = 1'b1;
    end
    chk("a.reach_5_2", 32'(seen), 32'd1);
    step(1'b0);
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? 1'b0 : 1'b1);
      chk("a.valid_while_off", 32'(obs[0].tim.valid), 32'd0);
      chk("b.valid_while_off", 32'(obs[1].tim.valid), 32'd0);
    end
    fr_hold = 16'(fb[0]);
    wait_strobe_a(8, seen, waited);
    chk("a.restart_seen", 32'(seen),      32'd1);
    chk("a.restart_lat",  32'(waited),    32'(A_D));
    chk("a.restart_x",    32'(obs[0].x),  32'd0);
    chk("a.restart_y",    32'(obs[0].y),  32'd0);
    chk("a.frame_hold",   32'(obs[0].fr), 32'(fr_hold));

    // Asynchronous reset between clock edges, mid-line.
    repeat (37) step(1'b1);
    @(negedge clk);
    compare_all();
    stats();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk_obs($sformatf("d%0d.async_rst", k), obs[k], idle_obs());
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      tt[k] = 0;
      fb[k] = 0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk_obs($sformatf("d%0d.rst_hold", k), obs[k], idle_obs());
    end
    rst_n = 1'b1;
    drive(1'b1);
    wait_strobe_a(8, seen, waited);
    chk("a.post_rst_seen", 32'(seen),      32'd1);
    chk("a.post_rst_lat",  32'(waited),    32'(A_D));
    chk("a.post_rst_x",    32'(obs[0].x),  32'd0);
    chk("a.post_rst_y",    32'(obs[0].y),  32'd0);
    chk("a.post_rst_fr",   32'(obs[0].fr), 32'd0);
    repeat (400) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
